// File: rtl/hdd_host_pkg.sv
// hdd_host_pkg: shared state type and constants for the slot-7 HDD host responder.
package hdd_host_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int BUF_AW       = $clog2(SECTOR_BYTES);
  localparam int LBA_W_DEF    = 16;
  localparam logic [7:0] ZERO_BYTE = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_ZERO_FILL,
    S_WR_REQ,
    S_WR_ADDR,
    S_WR_LATCH,
    S_WR_SEND,
    S_WR_COMMIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/hdd_host_wdog.sv
// hdd_host_wdog: idle watchdog; reload restarts the count, expire flags TIMEOUT_CYCLES idle cycles.
module hdd_host_wdog #(
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic reload,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk_sys) begin
    if (reset || reload) begin
      cnt_reg <= LOAD_VAL;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  // A beat in the same cycle always wins over expiry.
  assign expire = (cnt_reg == '0) & ~reload;

endmodule

// File: rtl/hdd_host.sv
// hdd_host: moves one sector between the HDD card's buffer port and a byte-stream block store.
// Optional build macro HDD_HOST_STATS_EN adds saturating read/write/error counters.
module hdd_host #(
  parameter int SECTOR_BYTES   = 512,
  parameter int LBA_W          = hdd_host_pkg::LBA_W_DEF,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic [LBA_W-1:0]                hdd_sector,
  input  logic                            hdd_read,
  input  logic                            hdd_write,
  output logic                            hdd_mounted,
  output logic                            hdd_protect,
  output logic [$clog2(SECTOR_BYTES)-1:0] ram_addr,
  output logic [7:0]                      ram_di,
  input  logic [7:0]                      ram_do,
  output logic                            ram_we,
  input  logic                            img_mounted,
  input  logic                            img_readonly,
  input  logic [LBA_W-1:0]                img_blocks,
  output logic                            blk_req,
  output logic                            blk_we,
  output logic [LBA_W-1:0]                blk_lba,
  input  logic                            blk_ack,
  input  logic [7:0]                      blk_rd_data,
  input  logic                            blk_rd_valid,
  output logic [7:0]                      blk_wr_data,
  output logic                            blk_wr_valid,
  input  logic                            blk_wr_ready,
  input  logic                            blk_done,
  output logic                            busy,
  output logic                            done,
  output logic                            err
`ifdef HDD_HOST_STATS_EN
  ,
  output logic [15:0]                     stat_rd,
  output logic [15:0]                     stat_wr,
  output logic [7:0]                      stat_err
`endif
);

  import hdd_host_pkg::*;

  localparam int AW = $clog2(SECTOR_BYTES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(SECTOR_BYTES - 1);

  state_t           state_reg;
  logic [AW-1:0]    count_reg;
  logic [LBA_W-1:0] sector_reg;
  logic [1:0]       req_lvl;
  logic [1:0]       req_q_reg;
  logic [1:0]       req_edge_reg;
  logic             rd_edge;
  logic             wr_edge;
  logic             wait_state;
  logic             beat;
  logic             wdog_expire;

  // Bit 0 tracks read, bit 1 write; the sector is sampled alongside the edge.
  assign req_lvl = {hdd_write, hdd_read};
  assign rd_edge = req_edge_reg[0];
  assign wr_edge = req_edge_reg[1];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      req_q_reg    <= '0;
      req_edge_reg <= '0;
      sector_reg   <= '0;
      hdd_mounted  <= 1'b0;
      hdd_protect  <= 1'b0;
    end else begin
      req_q_reg    <= req_lvl;
      req_edge_reg <= req_lvl & ~req_q_reg;
      sector_reg   <= hdd_sector;
      hdd_mounted  <= img_mounted;
      hdd_protect  <= img_mounted & img_readonly;
    end
  end

  always_comb begin
    wait_state = 1'b0;
    beat       = 1'b0;
    case (state_reg)
      S_RD_REQ, S_WR_REQ: begin wait_state = 1'b1; beat = blk_ack;      end
      S_RD_DATA:          begin wait_state = 1'b1; beat = blk_rd_valid; end
      S_WR_SEND:          begin wait_state = 1'b1; beat = blk_wr_ready; end
      S_WR_COMMIT:        begin wait_state = 1'b1; beat = blk_done;     end
      default: ;
    endcase
  end

  hdd_host_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_sys(clk_sys),
    .reset  (reset),
    .reload (~wait_state | beat),
    .expire (wdog_expire)
  );

  assign busy = (state_reg != S_IDLE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      blk_lba      <= '0;
      blk_req      <= 1'b0;
      blk_we       <= 1'b0;
      blk_wr_data  <= '0;
      blk_wr_valid <= 1'b0;
      ram_addr     <= '0;
      ram_di       <= '0;
      ram_we       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      done   <= (state_reg == S_DONE);
      if (state_reg != S_IDLE && (rd_edge || wr_edge)) err <= 1'b1;

      case (state_reg)
        S_IDLE: if (rd_edge || wr_edge) begin
          if (!hdd_mounted) begin
            err <= 1'b1;
          end else begin
            blk_lba   <= sector_reg;
            blk_we    <= ~rd_edge;
            count_reg <= '0;
            if (rd_edge) begin
              // A write edge arriving with the read is dropped but reported.
              err <= wr_edge;
              if (sector_reg >= img_blocks) begin
                state_reg <= S_ZERO_FILL;
              end else begin
                blk_req   <= 1'b1;
                state_reg <= S_RD_REQ;
              end
            end else if (sector_reg >= img_blocks || hdd_protect) begin
              err       <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              err       <= 1'b0;
              blk_req   <= 1'b1;
              state_reg <= S_WR_REQ;
            end
          end
        end
        S_RD_REQ, S_WR_REQ: begin
          if (blk_ack) begin
            blk_req <= 1'b0;
            if (blk_we) begin
              ram_addr  <= count_reg;
              state_reg <= S_WR_ADDR;
            end else begin
              state_reg <= S_RD_DATA;
            end
          end else if (wdog_expire) begin
            blk_req   <= 1'b0;
            err       <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_RD_DATA: begin
          if (blk_rd_valid) begin
            ram_addr  <= count_reg;
            ram_di    <= blk_rd_data;
            ram_we    <= 1'b1;
            count_reg <= count_reg + AW'(1);
            if (count_reg == LAST_ADDR) state_reg <= S_DONE;
          end else if (wdog_expire) begin
            err       <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_ZERO_FILL: begin
          ram_addr  <= count_reg;
          ram_di    <= ZERO_BYTE;
          ram_we    <= 1'b1;
          count_reg <= count_reg + AW'(1);
          if (count_reg == LAST_ADDR) begin
            err       <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        // ram_addr is already presented here, so ram_do is valid in WR_LATCH.
        S_WR_ADDR: state_reg <= S_WR_LATCH;
        S_WR_LATCH: begin
          blk_wr_data  <= ram_do;
          blk_wr_valid <= 1'b1;
          state_reg    <= S_WR_SEND;
        end
        S_WR_SEND: begin
          if (blk_wr_ready) begin
            blk_wr_valid <= 1'b0;
            count_reg    <= count_reg + AW'(1);
            ram_addr     <= count_reg + AW'(1);
            state_reg    <= (count_reg == LAST_ADDR) ? S_WR_COMMIT : S_WR_ADDR;
          end else if (wdog_expire) begin
            blk_wr_valid <= 1'b0;
            err          <= 1'b1;
            state_reg    <= S_DONE;
          end
        end
        S_WR_COMMIT: begin
          if (blk_done) begin
            state_reg <= S_DONE;
          end else if (wdog_expire) begin
            err       <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase

      // Image removal overrides whatever the transfer was doing.
      if (!img_mounted && state_reg != S_IDLE && state_reg != S_DONE) begin
        blk_req      <= 1'b0;
        blk_wr_valid <= 1'b0;
        ram_we       <= 1'b0;
        err          <= 1'b1;
        state_reg    <= S_DONE;
      end
    end
  end

`ifdef HDD_HOST_STATS_EN
  logic err_q_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      err_q_reg <= 1'b0;
      stat_rd   <= '0;
      stat_wr   <= '0;
      stat_err  <= '0;
    end else begin
      err_q_reg <= err;
      if (state_reg == S_DONE && !err) begin
        if (blk_we && stat_wr != '1) stat_wr <= stat_wr + 16'd1;
        if (!blk_we && stat_rd != '1) stat_rd <= stat_rd + 16'd1;
      end
      if (err && !err_q_reg && stat_err != '1) stat_err <= stat_err + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hdd_host.sv
// tb_hdd_host: directed stimulus with queued expectations checked by independent monitors.
`timescale 1ns/1ps
module tb_hdd_host;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] hdd_sector = '0;
  logic        hdd_read = 1'b0;
  logic        hdd_write = 1'b0;
  logic        hdd_mounted;
  logic        hdd_protect;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_di;
  logic [7:0]  ram_do;
  logic        ram_we;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic [15:0] img_blocks = '0;
  logic        blk_req;
  logic        blk_we;
  logic [15:0] blk_lba;
  logic        blk_ack = 1'b0;
  logic [7:0]  blk_rd_data = '0;
  logic        blk_rd_valid = 1'b0;
  logic [7:0]  blk_wr_data;
  logic        blk_wr_valid;
  logic        blk_wr_ready = 1'b0;
  logic        blk_done = 1'b0;
  logic        busy;
  logic        done;
  logic        err;

  hdd_host #(
    .SECTOR_BYTES(512),
    .LBA_W(16),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .hdd_sector(hdd_sector), .hdd_read(hdd_read), .hdd_write(hdd_write),
    .hdd_mounted(hdd_mounted), .hdd_protect(hdd_protect),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do), .ram_we(ram_we),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_blocks(img_blocks),
    .blk_req(blk_req), .blk_we(blk_we), .blk_lba(blk_lba), .blk_ack(blk_ack),
    .blk_rd_data(blk_rd_data), .blk_rd_valid(blk_rd_valid),
    .blk_wr_data(blk_wr_data), .blk_wr_valid(blk_wr_valid), .blk_wr_ready(blk_wr_ready),
    .blk_done(blk_done), .busy(busy), .done(done), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { logic [8:0] addr; logic [7:0] data; } ram_exp_t;
  typedef struct { logic [15:0] lba; logic we; } cmd_exp_t;

  ram_exp_t   exp_ram_q[$];
  cmd_exp_t   exp_cmd_q[$];
  logic [7:0] exp_wr_q[$];
  logic       exp_done_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int wr_beats = 0;
  bit req_seen = 1'b0;
  logic preload_req = 1'b0;
  logic [7:0] card_mem [512];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    while (!blk_req && k < 20) begin tick(); k++; end
    chk(name, 32'(blk_req), 32'd1);
  endtask

  task automatic wait_done(input string name, input int limit, output int cycles);
    int k;
    k = 0;
    while (!done && k < limit) begin tick(); k++; end
    chk(name, 32'(done), 32'd1);
    cycles = k;
  endtask

  // Card sector buffer: registered read, byte write strobe.
  always @(posedge clk_sys) begin
    if (preload_req) begin
      for (int a = 0; a < 512; a++) card_mem[a] <= 8'(a) ^ 8'hA5;
    end else if (ram_we) begin
      card_mem[ram_addr] <= ram_di;
    end
    ram_do <= card_mem[ram_addr];
  end

  always @(negedge clk_sys) begin
    if (ram_we) begin
      if (exp_ram_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ram_we_unexpected: got addr %0d data %0h, expected no write", ram_addr, ram_di);
      end else begin
        ram_exp_t e;
        e = exp_ram_q.pop_front();
        chk("ram_addr", 32'(ram_addr), 32'(e.addr));
        chk("ram_di", 32'(ram_di), 32'(e.data));
      end
    end
    if (blk_wr_valid && blk_wr_ready) begin
      wr_beats++;
      if (exp_wr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wr_beat_unexpected: got %0h, expected no beat", blk_wr_data);
      end else begin
        logic [7:0] w;
        w = exp_wr_q.pop_front();
        chk("blk_wr_data", 32'(blk_wr_data), 32'(w));
      end
    end
    if (blk_req) req_seen = 1'b1;
    if (blk_req && blk_ack) begin
      if (exp_cmd_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL cmd_unexpected: got lba %0d we %0b, expected no command", blk_lba, blk_we);
      end else begin
        cmd_exp_t c;
        c = exp_cmd_q.pop_front();
        chk("blk_lba", 32'(blk_lba), 32'(c.lba));
        chk("blk_we", 32'(blk_we), 32'(c.we));
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_done_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done_unexpected: got done with err %0b, expected none", err);
      end else begin
        logic e_err;
        e_err = exp_done_q.pop_front();
        chk("done_err", 32'(err), 32'(e_err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int cyc;
    int dc;
    int k;
    cmd_exp_t c;
    ram_exp_t r;

    // Reset: outputs held low even with an image present.
    img_mounted = 1'b1;
    img_blocks  = 16'd100;
    repeat (3) tick();
    chk("rst_mounted", 32'(hdd_mounted), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_blk_req", 32'(blk_req), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    reset = 1'b0;
    tick(); tick();
    chk("mounted", 32'(hdd_mounted), 32'd1);
    chk("protect_off", 32'(hdd_protect), 32'd0);

    // Read sector 5, store streams i&0xFF with gaps, plus one extra byte.
    for (int i = 0; i < 512; i++) begin r.addr = 9'(i); r.data = 8'(i); exp_ram_q.push_back(r); end
    c.lba = 16'd5; c.we = 1'b0; exp_cmd_q.push_back(c);
    exp_done_q.push_back(1'b0);
    hdd_sector = 16'd5; hdd_read = 1'b1;
    tick();
    wait_req("t1_req");
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    for (int i = 0; i < 512; i++) begin
      blk_rd_data = 8'(i); blk_rd_valid = 1'b1; tick();
      if (i % 7 == 6) begin blk_rd_valid = 1'b0; tick(); end
    end
    blk_rd_data = 8'hEE; tick();
    blk_rd_valid = 1'b0;
    wait_done("t1_done", 10, cyc);
    hdd_read = 1'b0; tick();
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_ram_left", 32'(exp_ram_q.size()), 32'd0);

    // Write to a protected image: no bus activity, quick done with err.
    img_readonly = 1'b1; tick(); tick();
    chk("t3_protect", 32'(hdd_protect), 32'd1);
    req_seen = 1'b0;
    exp_done_q.push_back(1'b1);
    hdd_sector = 16'd7; hdd_write = 1'b1;
    wait_done("t3_done_within_3", 3, cyc);
    chk("t3_no_req", 32'(req_seen), 32'd0);
    hdd_write = 1'b0; img_readonly = 1'b0; tick(); tick();

    // Read past the end of the image: 512 zero writes, no command, err.
    for (int i = 0; i < 512; i++) begin r.addr = 9'(i); r.data = 8'h00; exp_ram_q.push_back(r); end
    exp_done_q.push_back(1'b1);
    req_seen = 1'b0;
    hdd_sector = 16'd100; hdd_read = 1'b1;
    wait_done("t4_done", 600, cyc);
    chk("t4_no_req", 32'(req_seen), 32'd0);
    hdd_read = 1'b0; tick();
    chk("t4_ram_left", 32'(exp_ram_q.size()), 32'd0);

    // Store stalls after byte 200: watchdog aborts after 64 idle cycles.
    for (int i = 0; i <= 200; i++) begin r.addr = 9'(i); r.data = 8'(i * 3); exp_ram_q.push_back(r); end
    c.lba = 16'd9; c.we = 1'b0; exp_cmd_q.push_back(c);
    exp_done_q.push_back(1'b1);
    hdd_sector = 16'd9; hdd_read = 1'b1;
    tick();
    wait_req("t5_req");
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    for (int i = 0; i <= 200; i++) begin blk_rd_data = 8'(i * 3); blk_rd_valid = 1'b1; tick(); end
    blk_rd_valid = 1'b0;
    wait_done("t5_done", 200, cyc);
    chk("t5_timeout_in_64_to_66", 32'((cyc >= 64) && (cyc <= 66)), 32'd1);
    tick();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_ram_left", 32'(exp_ram_q.size()), 32'd0);
    hdd_read = 1'b0; tick();

    // Write sector 7 from a buffer holding 0xA5^addr, ready toggling.
    preload_req = 1'b1; tick(); preload_req = 1'b0;
    for (int i = 0; i < 512; i++) exp_wr_q.push_back(8'(i) ^ 8'hA5);
    c.lba = 16'd7; c.we = 1'b1; exp_cmd_q.push_back(c);
    exp_done_q.push_back(1'b0);
    wr_beats = 0;
    hdd_sector = 16'd7; hdd_write = 1'b1;
    tick();
    wait_req("t2_req");
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    k = 0;
    while (wr_beats < 512 && k < 5000) begin blk_wr_ready = ~blk_wr_ready; tick(); k++; end
    blk_wr_ready = 1'b0;
    chk("t2_beats", 32'(wr_beats), 32'd512);
    dc = done_cnt;
    repeat (3) tick();
    chk("t2_no_done_before_commit", 32'(done_cnt), 32'(dc));
    blk_done = 1'b1; tick(); blk_done = 1'b0;
    wait_done("t2_done", 5, cyc);
    hdd_write = 1'b0; tick();
    chk("t2_err", 32'(err), 32'd0);

    // Read and write edges together, a re-edge while busy, reset at byte 300.
    for (int i = 0; i < 300; i++) begin r.addr = 9'(i); r.data = 8'(i) ^ 8'h5A; exp_ram_q.push_back(r); end
    c.lba = 16'd3; c.we = 1'b0; exp_cmd_q.push_back(c);
    hdd_sector = 16'd3; hdd_read = 1'b1; hdd_write = 1'b1;
    tick();
    wait_req("t6_req");
    chk("t6_err_collision", 32'(err), 32'd1);
    blk_ack = 1'b1; tick(); blk_ack = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 100) hdd_read = 1'b0;
      if (i == 110) hdd_read = 1'b1;
      if (i == 150) begin
        chk("t6_busy_mid", 32'(busy), 32'd1);
        chk("t6_err_mid", 32'(err), 32'd1);
      end
      blk_rd_data = 8'(i) ^ 8'h5A; blk_rd_valid = 1'b1; tick();
    end
    blk_rd_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    chk("t6_rst_blk_req", 32'(blk_req), 32'd0);
    chk("t6_rst_blk_wr_valid", 32'(blk_wr_valid), 32'd0);
    chk("t6_rst_ram_we", 32'(ram_we), 32'd0);
    chk("t6_rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("t6_rst_blk_lba", 32'(blk_lba), 32'd0);
    chk("t6_rst_mounted", 32'(hdd_mounted), 32'd0);
    hdd_read = 1'b0; hdd_write = 1'b0;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("end_ram_q", 32'(exp_ram_q.size()), 32'd0);
    chk("end_cmd_q", 32'(exp_cmd_q.size()), 32'd0);
    chk("end_wr_q", 32'(exp_wr_q.size()), 32'd0);
    chk("end_done_q", 32'(exp_done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdd_host.md
Name: hdd_host

Overview:
- Host-side responder for the slot-7 hard-disk card's sector interface.
- Watches the card's sector read/write requests and moves one 512-byte sector between the card's sector buffer port (ram_addr/ram_di/ram_do/ram_we) and a backing block store on a byte-stream interface.
- Drives the card's mounted/protect status.
- Sits in the top level between the card and the platform storage bridge.

Parameters:
- SECTOR_BYTES, 512, bytes per sector; buffer address width = clog2(SECTOR_BYTES) = 9.
- LBA_W, 16, sector number width.
- TIMEOUT_CYCLES, 1048576, idle cycles without a byte beat or ack before abort.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- hdd_sector  in  LBA_W  sector number from card, sampled on request edge
- hdd_read  in  1  card read request (level; rising edge starts transfer)
- hdd_write  in  1  card write request (level; rising edge starts transfer)
- hdd_mounted  out  1  image present to card
- hdd_protect  out  1  image write-protected
- ram_addr  out  9  card sector-buffer address
- ram_di  out  8  byte into card buffer
- ram_do  in  8  byte from card buffer, valid 1 cycle after ram_addr
- ram_we  out  1  card buffer write strobe
- img_mounted  in  1  platform image present
- img_readonly  in  1  platform image read-only
- img_blocks  in  LBA_W  image size in sectors
- blk_req  out  1  block command request, held until blk_ack
- blk_we  out  1  command is write (valid with blk_req)
- blk_lba  out  LBA_W  command sector
- blk_ack  in  1  command accepted (1-cycle)
- blk_rd_data  in  8  read byte
- blk_rd_valid  in  1  read byte strobe
- blk_wr_data  out  8  write byte
- blk_wr_valid  out  1  write byte valid, held until blk_wr_ready
- blk_wr_ready  in  1  write byte accepted
- blk_done  in  1  store finished committing write
- busy  out  1  transfer in progress
- done  out  1  1-cycle completion pulse
- err  out  1  sticky error of last transfer; cleared on next accepted request

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, edge registers 0.
- Status: hdd_mounted = registered img_mounted; hdd_protect = registered img_mounted & img_readonly (1-cycle latency).
- Edge detect: req = hdd_x & ~hdd_x_q, registered.
- Only in IDLE with hdd_mounted=1 is a request accepted. Edges while busy or unmounted are dropped and set err.
- Simultaneous read and write edges: read wins; write dropped; err set.
- On acceptance, hdd_sector is latched into blk_lba.
- Read range check: sector >= img_blocks -> ZERO_FILL writes 0x00 to all 512 addresses (ram_we 1/cycle), then sets err and goes to DONE.
- Write range check: sector >= img_blocks, or hdd_protect=1 -> DONE with err, no bus activity.
- States: IDLE, RD_REQ, RD_DATA, ZERO_FILL, WR_REQ, WR_ADDR, WR_LATCH, WR_SEND, WR_COMMIT, DONE.
- RD_REQ: blk_req=1, blk_we=0, until blk_ack.
- RD_DATA: each blk_rd_valid gives ram_addr=count, ram_di=data, ram_we=1 on the next cycle; count++.
  - After byte 511 -> DONE. Extra bytes are ignored.
- WR_REQ: blk_req=1, blk_we=1, until blk_ack.
- Write byte loop:
  - WR_ADDR drives ram_addr=count.
  - WR_LATCH captures ram_do into blk_wr_data.
  - WR_SEND holds blk_wr_valid until blk_wr_ready, then count++.
  - Loop to WR_ADDR until 512 bytes sent, then WR_COMMIT waits blk_done.
- DONE: done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- Counter is 9 bits; wrap at 511->0 marks last byte.
- Watchdog: in any wait state (REQ, RD_DATA, WR_SEND, WR_COMMIT), reaching TIMEOUT_CYCLES with no ack/valid/ready/done -> DONE with err. Watchdog reloads on each beat.
- img_mounted falling mid-transfer: abort. Deassert blk_req and blk_wr_valid next cycle, set err, go to DONE.
- reset mid-transfer: immediate return to reset state; no done pulse.

Optional Feature:
- HDD_HOST_STATS_EN:
  - Defined: adds outputs stat_rd (16), stat_wr (16), stat_err (8). These are saturating counts of completed error-free reads, completed error-free writes, and err assertions. Cleared by reset.
  - Undefined: ports absent, no counters; behaviour otherwise identical.

Decomposition:
- Package hdd_host_pkg: state enum, SECTOR_BYTES, BUF_AW=9, LBA_W default, ZERO_BYTE constant.
- One sub-module, hdd_host_wdog: loadable down-counter with reload and expire outputs, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Mounted, img_blocks=100, hdd_read rise with sector=5; store streams bytes i&0xFF -> blk_lba=5, 512 ram_we pulses with ram_addr=i and ram_di=i&0xFF, one done, err=0.
- Card buffer preloaded with 0xA5^addr, hdd_write sector=7, blk_wr_ready toggling every other cycle -> 512 bytes match, blk_done then done, err=0.
- img_readonly=1, hdd_write -> no blk_req, done in ≤3 cycles, err=1.
- Read sector=100 with img_blocks=100 -> 512 zero writes, no blk_req, err=1.
- Read with blk_rd_valid stalled after byte 200, TIMEOUT_CYCLES=64 -> abort after 64 idle cycles, err=1, busy=0.
- hdd_read and hdd_write rise same cycle, and a second read edge while busy -> read serviced, extra edges ignored, err=1; reset asserted at byte 300 -> all outputs 0 next cycle.
